// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipe_skid_stage pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY,
        PIPE_ONE,
        PIPE_TWO
    } pipe_state_e;

    localparam int PIPE_OCC_W  = 2;
    localparam int PIPE_PERF_W = 32;

    function automatic logic [PIPE_OCC_W-1:0] occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control field (zeroed on flush) and data field (held on flush).
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear_valid,
    input  logic                  flush,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  valid,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end else if (clear_valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and synchronous flush.
// Optional PIPE_SKID_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [PIPE_OCC_W-1:0]  occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [PIPE_PERF_W-1:0] stall_cnt,
    output logic [PIPE_PERF_W-1:0] flush_cnt
`endif
);

    logic                  m_valid, s_valid;
    logic [CTRL_WIDTH-1:0] m_ctrl, s_ctrl, m_ctrl_nxt;
    logic [DATA_WIDTH-1:0] m_data, s_data, m_data_nxt;
    logic                  m_load, m_clear, m_from_skid;
    logic                  s_load, s_clear;
    logic                  accept, drain;
    pipe_state_e           state;

    // Skid valid is a register, so in_ready never depends on out_ready combinationally.
    assign in_ready  = ~s_valid;
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = m_valid & out_ready & ~flush;
    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;
    assign occupancy = occ_count(m_valid, s_valid);

    // The state register is the pair of slot valid bits.
    always_comb begin
        if (s_valid)      state = PIPE_TWO;
        else if (m_valid) state = PIPE_ONE;
        else              state = PIPE_EMPTY;
    end

    always_comb begin
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        unique case (state)
            PIPE_EMPTY: m_load = accept;
            PIPE_ONE: begin
                if (accept && drain)  m_load  = 1'b1;
                else if (accept)      s_load  = 1'b1;
                else if (drain)       m_clear = 1'b1;
            end
            PIPE_TWO: begin
                if (drain) begin
                    m_load      = 1'b1;
                    m_from_skid = 1'b1;
                    s_clear     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign m_ctrl_nxt = m_from_skid ? s_ctrl : in_ctrl;
    assign m_data_nxt = m_from_skid ? s_data : in_data;

    pipe_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (m_load),
        .clear_valid (m_clear),
        .flush       (flush),
        .in_ctrl     (m_ctrl_nxt),
        .in_data     (m_data_nxt),
        .valid       (m_valid),
        .ctrl        (m_ctrl),
        .data        (m_data)
    );

    pipe_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (s_load),
        .clear_valid (s_clear),
        .flush       (flush),
        .in_ctrl     (in_ctrl),
        .in_data     (in_data),
        .valid       (s_valid),
        .ctrl        (s_ctrl),
        .data        (s_data)
    );

`ifdef PIPE_SKID_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule
